fetch_ctrl: RTL and testbench

- Fetch sequencer for the 5-stage pipeline; sits between the PC/IF logic and a handshaked instruction memory.
- Issues fetch requests and arbitrates EXE redirects (jalr/jal/branch) against hazard stalls and variable-latency memory.
- Owns the IF/ID pipeline register, bubble insertion, and the ID/EX flush pulse on redirect.

---
 rtl/fetch_pkg.sv | 26 ++
 rtl/fetch_redirect_sel.sv | 43 ++++
 rtl/fetch_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_fetch_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and default constants for the fetch sequencer.
//   fetch_state_t : sequencer states (BOOT, FETCH, HOLD, DROP)
//   redir_src_t   : which EXE source wins the redirect (NONE, BR, JAL, JALR)
//   DEF_*         : default parameter values for fetch_ctrl
package fetch_pkg;

    localparam int unsigned DEF_PC_W     = 15;
    localparam int unsigned DEF_INSTR_W  = 32;
    localparam int unsigned DEF_RESET_PC = 0;
    localparam int unsigned DEF_PC_STEP  = 4;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DROP  = 2'd3
    } fetch_state_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        BR   = 2'd1,
        JAL  = 2'd2,
        JALR = 2'd3
    } redir_src_t;

endpackage

// File: rtl/fetch_redirect_sel.sv
// fetch_redirect_sel: combinational priority select of the EXE redirect.
// Priority jalr > jal > branch.
// Ports:
//   branch_EXE/jal_EXE/jalr_EXE           : redirect requests
//   branch/jal/jalr_address_EXE [PC_W]    : corresponding targets
//   redir                                  : any redirect requested
//   target [PC_W]                          : winning target (0 when none)
module fetch_redirect_sel
    import fetch_pkg::*;
#(
    parameter int unsigned PC_W = DEF_PC_W
) (
    input  logic            branch_EXE,
    input  logic            jal_EXE,
    input  logic            jalr_EXE,
    input  logic [PC_W-1:0] branch_address_EXE,
    input  logic [PC_W-1:0] jal_address_EXE,
    input  logic [PC_W-1:0] jalr_address_EXE,
    output logic            redir,
    output logic [PC_W-1:0] target
);

    redir_src_t src;

    always_comb begin
        if (jalr_EXE)        src = JALR;
        else if (jal_EXE)    src = JAL;
        else if (branch_EXE) src = BR;
        else                 src = NONE;
    end

    always_comb begin
        case (src)
            JALR:    target = jalr_address_EXE;
            JAL:     target = jal_address_EXE;
            BR:      target = branch_address_EXE;
            default: target = '0;
        endcase
    end

    assign redir = (src != NONE);

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch sequencer between PC/IF logic and a handshaked
// instruction memory. Owns the IF/ID register, bubble insertion, a one-entry
// skid buffer for data returning during a hazard stall, and the ID/EX flush.
// Ports:
//   clk, reset (async, active-high)
//   pc_write_HZRD            : 1 = pipeline advances, 0 = hold IF/ID
//   branch/jal/jalr_EXE(+_address_EXE) : EXE redirects (jalr > jal > branch)
//   imem_req/imem_addr       : fetch request, address stable until imem_ack
//   imem_ack/imem_rdata      : request complete, instruction data
//   instruction_IF_ID/pc_IF_ID/valid_IF_ID : IF/ID register (valid=0 bubble)
//   flush_ID_EX              : one-cycle pulse after each redirect cycle
// Optional: `define FETCH_CTRL_PERF_EN adds perf_fetched / perf_redirects.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned PC_W     = DEF_PC_W,
    parameter int unsigned INSTR_W  = DEF_INSTR_W,
    parameter int unsigned RESET_PC = DEF_RESET_PC,
    parameter int unsigned PC_STEP  = DEF_PC_STEP
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pc_write_HZRD,
    input  logic               branch_EXE,
    input  logic               jal_EXE,
    input  logic               jalr_EXE,
    input  logic [PC_W-1:0]    branch_address_EXE,
    input  logic [PC_W-1:0]    jal_address_EXE,
    input  logic [PC_W-1:0]    jalr_address_EXE,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instruction_IF_ID,
    output logic [PC_W-1:0]    pc_IF_ID,
    output logic               valid_IF_ID,
    output logic               flush_ID_EX
`ifdef FETCH_CTRL_PERF_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_redirects
`endif
);

    localparam logic [PC_W-1:0] PC_RST = PC_W'(RESET_PC);
    localparam logic [PC_W-1:0] PC_INC = PC_W'(PC_STEP);

    fetch_state_t       state;
    logic [PC_W-1:0]    pc_q;
    logic [PC_W-1:0]    addr_q;
    logic [PC_W-1:0]    pc_seq;
    logic [PC_W-1:0]    target;
    logic               redir;
    // Skid buffer contents are meaningful only while in HOLD.
    logic [INSTR_W-1:0] skid_instr;
    logic [PC_W-1:0]    skid_pc;

    fetch_redirect_sel #(
        .PC_W(PC_W)
    ) u_redirect_sel (
        .branch_EXE         (branch_EXE),
        .jal_EXE            (jal_EXE),
        .jalr_EXE           (jalr_EXE),
        .branch_address_EXE (branch_address_EXE),
        .jal_address_EXE    (jal_address_EXE),
        .jalr_address_EXE   (jalr_address_EXE),
        .redir              (redir),
        .target             (target)
    );

    assign pc_seq    = pc_q + PC_INC;
    assign imem_addr = addr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= BOOT;
            pc_q              <= PC_RST;
            addr_q            <= '0;
            imem_req          <= 1'b0;
            instruction_IF_ID <= '0;
            pc_IF_ID          <= '0;
            valid_IF_ID       <= 1'b0;
            flush_ID_EX       <= 1'b0;
            skid_instr        <= '0;
            skid_pc           <= '0;
        end else begin
            flush_ID_EX <= redir;
            case (state)
                BOOT: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                    if (redir) begin
                        pc_q   <= target;
                        addr_q <= target;
                    end else begin
                        addr_q <= pc_q;
                    end
                end

                FETCH: begin
                    if (redir) begin
                        pc_q        <= target;
                        valid_IF_ID <= 1'b0;
                        if (imem_ack) begin
                            addr_q <= target;
                        end else begin
                            // request still in flight: finish it at the old address
                            state <= DROP;
                        end
                    end else if (imem_ack) begin
                        pc_q <= pc_seq;
                        if (pc_write_HZRD) begin
                            instruction_IF_ID <= imem_rdata;
                            pc_IF_ID          <= addr_q;
                            valid_IF_ID       <= 1'b1;
                            addr_q            <= pc_seq;
                        end else begin
                            skid_instr <= imem_rdata;
                            skid_pc    <= addr_q;
                            state      <= HOLD;
                            imem_req   <= 1'b0;
                        end
                    end else if (pc_write_HZRD) begin
                        valid_IF_ID <= 1'b0;
                    end
                end

                HOLD: begin
                    if (redir) begin
                        pc_q        <= target;
                        addr_q      <= target;
                        valid_IF_ID <= 1'b0;
                        state       <= FETCH;
                        imem_req    <= 1'b1;
                    end else if (pc_write_HZRD) begin
                        instruction_IF_ID <= skid_instr;
                        pc_IF_ID          <= skid_pc;
                        valid_IF_ID       <= 1'b1;
                        addr_q            <= pc_q;
                        state             <= FETCH;
                        imem_req          <= 1'b1;
                    end
                end

                DROP: begin
                    valid_IF_ID <= 1'b0;
                    if (redir) begin
                        pc_q <= target;
                        // a redirect landing on the draining ack can restart directly
                        if (imem_ack) begin
                            addr_q <= target;
                            state  <= FETCH;
                        end
                    end else if (imem_ack) begin
                        addr_q <= pc_q;
                        state  <= FETCH;
                    end
                end

                default: begin
                    state    <= BOOT;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_CTRL_PERF_EN
    logic wr_valid;

    assign wr_valid = !redir && pc_write_HZRD &&
                      ((state == FETCH && imem_ack) || state == HOLD);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetched   <= '0;
            perf_redirects <= '0;
        end else begin
            if (wr_valid) perf_fetched   <= perf_fetched + 32'd1;
            if (redir)    perf_redirects <= perf_redirects + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed scenarios followed by randomized stimulus.
// The reference model states the delivered IF/ID stream as "consecutive PCs
// from the last redirect target"; the expected stream is queued when stimulus
// is issued and popped by the monitor on each new valid IF/ID entry.
module tb_fetch_ctrl;

    localparam int unsigned PC_W    = 15;
    localparam int unsigned INSTR_W = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic pc_write_HZRD = 1'b0;
    logic branch_EXE = 1'b0, jal_EXE = 1'b0, jalr_EXE = 1'b0;
    logic [PC_W-1:0] branch_address_EXE = '0, jal_address_EXE = '0, jalr_address_EXE = '0;
    logic imem_req, imem_ack;
    logic [PC_W-1:0] imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic [INSTR_W-1:0] instruction_IF_ID;
    logic [PC_W-1:0] pc_IF_ID;
    logic valid_IF_ID, flush_ID_EX;
`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] perf_fetched, perf_redirects;
`endif

    int checks = 0, errors = 0;
    int mem_lat = 0;
    int mem_cnt = 0;
    logic [PC_W-1:0] exp_q[$];
    logic [PC_W-1:0] next_pc = '0;
    bit redir_seen = 0, adv = 0;
    int redir_cycles = 0, fetched = 0, deliveries = 0, idle = 0;
    bit pv = 0, p_req = 0, p_ack = 0;
    logic [PC_W-1:0] ppc = '0, p_addr = '0;
    logic [INSTR_W-1:0] pinstr = '0;

    always #5 clk = ~clk;

    fetch_ctrl #(
        .PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC(0), .PC_STEP(4)
    ) dut (
        .clk(clk), .reset(reset), .pc_write_HZRD(pc_write_HZRD),
        .branch_EXE(branch_EXE), .jal_EXE(jal_EXE), .jalr_EXE(jalr_EXE),
        .branch_address_EXE(branch_address_EXE), .jal_address_EXE(jal_address_EXE),
        .jalr_address_EXE(jalr_address_EXE),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instruction_IF_ID(instruction_IF_ID), .pc_IF_ID(pc_IF_ID),
        .valid_IF_ID(valid_IF_ID), .flush_ID_EX(flush_ID_EX)
`ifdef FETCH_CTRL_PERF_EN
        , .perf_fetched(perf_fetched), .perf_redirects(perf_redirects)
`endif
    );

    function automatic logic [INSTR_W-1:0] mem_word(input logic [PC_W-1:0] a);
        return {a ^ 15'h5A5A, 2'b10, a};
    endfunction

    // Memory: mem_cnt wait cycles per request, then ack (0 = same-cycle ack).
    assign imem_ack   = imem_req && (mem_cnt == 0);
    assign imem_rdata = imem_ack ? mem_word(imem_addr) : ~mem_word(imem_addr);

    always @(posedge clk) begin
        if (!imem_req || imem_ack)
            mem_cnt <= (mem_lat < 0) ? int'($urandom_range(0, 3)) : mem_lat;
        else if (mem_cnt > 0)
            mem_cnt <= mem_cnt - 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: applied to the inputs about to be sampled.
    task automatic issue();
        if (reset) begin
            exp_q.delete();
            next_pc      = '0;
            redir_seen   = 0;
            adv          = 0;
            redir_cycles = 0;
        end else begin
            redir_seen = jalr_EXE | jal_EXE | branch_EXE;
            adv        = pc_write_HZRD | redir_seen;
            if (redir_seen) begin
                exp_q.delete();
                next_pc = jalr_EXE ? jalr_address_EXE :
                          jal_EXE  ? jal_address_EXE  : branch_address_EXE;
                redir_cycles++;
            end
        end
        while (exp_q.size() < 4) begin
            exp_q.push_back(next_pc);
            next_pc = next_pc + 15'd4;
        end
    endtask

    task automatic monitor();
        logic [PC_W-1:0] e;
        if (reset) begin
            pv = 0; p_req = 0; p_ack = 0; fetched = 0; idle = 0;
            return;
        end
        chk("flush", flush_ID_EX, redir_seen);
        if (redir_seen) begin
            chk("redir_bubble", valid_IF_ID, 0);
        end else if (!adv) begin
            chk("stall_valid", valid_IF_ID, pv);
            if (pv) begin
                chk("stall_pc", pc_IF_ID, ppc);
                chk("stall_instr", instruction_IF_ID, pinstr);
            end
        end else if (valid_IF_ID) begin
            e = exp_q.pop_front();
            chk("ifid_pc", pc_IF_ID, e);
            chk("ifid_instr", instruction_IF_ID, mem_word(e));
            deliveries++;
            fetched++;
            idle = 0;
        end
        if (!(adv && valid_IF_ID)) begin
            idle++;
            if (idle > 100) begin
                checks++;
                errors++;
                $display("FAIL progress: %0d cycles without delivery, limit 100", idle);
                idle = 0;
            end
        end
        if (p_req && !p_ack) begin
            chk("req_hold", imem_req, 1);
            chk("addr_hold", imem_addr, p_addr);
        end
        p_req = imem_req; p_ack = imem_ack; p_addr = imem_addr;
        pv = valid_IF_ID; ppc = pc_IF_ID; pinstr = instruction_IF_ID;
    endtask

    task automatic cyc();
        issue();
        @(posedge clk);
        @(negedge clk);
        monitor();
    endtask

    task automatic clr_redir();
        branch_EXE = 0; jal_EXE = 0; jalr_EXE = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        cyc();
        cyc();
        reset = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        // Reset values
        mem_lat = 0;
        cyc();
        cyc();
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_instr", instruction_IF_ID, 0);
        chk("rst_pc", pc_IF_ID, 0);
        chk("rst_valid", valid_IF_ID, 0);
        chk("rst_flush", flush_ID_EX, 0);
        reset = 0;

        // 1: zero-wait memory, no stalls
        pc_write_HZRD = 1;
        cyc();
        chk("t1_boot_req", imem_req, 1);
        chk("t1_boot_addr", imem_addr, 0);
        chk("t1_boot_valid", valid_IF_ID, 0);
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("t1_valid", valid_IF_ID, 1);
            chk("t1_pc", pc_IF_ID, 64'(4 * k));
        end

        // 2: stall while pc 8 is acked
        do_reset();
        pc_write_HZRD = 1;
        cyc(); cyc(); cyc();
        pc_write_HZRD = 0;
        cyc();
        chk("t2_hold_pc", pc_IF_ID, 4);
        chk("t2_hold_req", imem_req, 0);
        cyc();
        chk("t2_hold_pc2", pc_IF_ID, 4);
        chk("t2_hold_req2", imem_req, 0);
        pc_write_HZRD = 1;
        cyc();
        chk("t2_rel_pc", pc_IF_ID, 8);
        chk("t2_rel_valid", valid_IF_ID, 1);
        cyc();
        chk("t2_next_pc", pc_IF_ID, 12);

        // 3: branch to 24
        branch_EXE = 1; branch_address_EXE = 15'd24;
        cyc();
        chk("t3_flush", flush_ID_EX, 1);
        chk("t3_bubble", valid_IF_ID, 0);
        clr_redir();
        cyc();
        chk("t3_flush_end", flush_ID_EX, 0);
        chk("t3_pc24", pc_IF_ID, 24);
        cyc();
        chk("t3_pc28", pc_IF_ID, 28);

        // 4: all three redirects with a stall: jalr wins
        jal_EXE = 1; jal_address_EXE = 15'd8;
        jalr_EXE = 1; jalr_address_EXE = 15'd4;
        branch_EXE = 1; branch_address_EXE = 15'd24;
        pc_write_HZRD = 0;
        cyc();
        chk("t4_flush", flush_ID_EX, 1);
        clr_redir();
        pc_write_HZRD = 1;
        cyc();
        chk("t4_pc", pc_IF_ID, 4);
        chk("t4_valid", valid_IF_ID, 1);

        // 5: jalr while pc 12 is outstanding (3 wait cycles)
        do_reset();
        pc_write_HZRD = 1;
        cyc(); cyc(); cyc();
        mem_lat = 3;
        cyc();
        chk("t5_out_addr", imem_addr, 12);
        jalr_EXE = 1; jalr_address_EXE = 15'd4;
        cyc();
        clr_redir();
        chk("t5_drop_req", imem_req, 1);
        chk("t5_drop_addr", imem_addr, 12);
        cyc();
        chk("t5_drop_addr2", imem_addr, 12);
        cyc();
        chk("t5_drop_ack", imem_ack, 1);
        chk("t5_drop_addr3", imem_addr, 12);
        cyc();
        chk("t5_new_addr", imem_addr, 4);
        chk("t5_new_req", imem_req, 1);
        mem_lat = 0;
        for (int k = 0; k < 12 && !valid_IF_ID; k++) cyc();
        chk("t5_pc", pc_IF_ID, 4);
        chk("t5_valid", valid_IF_ID, 1);

        // 6a: PC wrap at 2^15
        jalr_EXE = 1; jalr_address_EXE = 15'h7FFC;
        cyc();
        clr_redir();
        cyc();
        chk("t6_pc_top", pc_IF_ID, 15'h7FFC);
        chk("t6_wrap_addr", imem_addr, 0);
        cyc();
        chk("t6_pc_wrap", pc_IF_ID, 0);

        // 6b: reset asserted while in DROP
        mem_lat = 3;
        cyc();
        jalr_EXE = 1; jalr_address_EXE = 15'h40;
        cyc();
        clr_redir();
        chk("t6_drop_req", imem_req, 1);
        chk("t6_drop_flush", flush_ID_EX, 1);
        #1 reset = 1;
        #1;
        chk("t6_rst_req", imem_req, 0);
        chk("t6_rst_addr", imem_addr, 0);
        chk("t6_rst_valid", valid_IF_ID, 0);
        chk("t6_rst_pc", pc_IF_ID, 0);
        chk("t6_rst_instr", instruction_IF_ID, 0);
        chk("t6_rst_flush", flush_ID_EX, 0);
        mem_lat = 0;
        cyc();
        reset = 0;
        cyc();
        chk("t6_restart_addr", imem_addr, 0);
        chk("t6_restart_req", imem_req, 1);
        cyc();
        chk("t6_restart_pc", pc_IF_ID, 0);

        // Randomized phase
        mem_lat = -1;
        deliveries = 0;
        for (int i = 0; i < 3000; i++) begin
            pc_write_HZRD = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) begin
                branch_EXE = 1'($urandom_range(0, 1));
                jal_EXE    = 1'($urandom_range(0, 1));
                jalr_EXE   = 1'($urandom_range(0, 1));
            end else begin
                clr_redir();
            end
            branch_address_EXE = PC_W'($urandom) & 15'h7FFC;
            jal_address_EXE    = PC_W'($urandom) & 15'h7FFC;
            jalr_address_EXE   = PC_W'($urandom) & 15'h7FFC;
            cyc();
        end
        chk("rand_progress", 64'(deliveries >= 200), 1);
`ifdef FETCH_CTRL_PERF_EN
        chk("perf_fetched", perf_fetched, 64'(fetched));
        chk("perf_redirects", perf_redirects, 64'(redir_cycles));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
